alu_request_arbiter: RTL and testbench

//   Shares the single ArithmeticLogicUnit between two requesters (e.g. fetch/address path and execute path).

---
 rtl/alu_request_arbiter.sv | 159 +++++++++++++++
 tb/tb_alu_request_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_request_arbiter.sv
// rtl/alu_request_arbiter.sv - shares one ALU between two requesters, iterating each command Count times
// Optional macro ALU_ARB_RR_EN: round-robin arbitration; undefined gives fixed priority with Req0 first.
module alu_request_arbiter #(
  parameter int CNT_W = 5
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Req0,
  input  logic             Req1,
  input  logic [4:0]       FunSel0,
  input  logic [4:0]       FunSel1,
  input  logic [31:0]      A0,
  input  logic [31:0]      A1,
  input  logic [31:0]      B0,
  input  logic [31:0]      B1,
  input  logic [CNT_W-1:0] Cnt0,
  input  logic [CNT_W-1:0] Cnt1,
  output logic             Ack0,
  output logic             Ack1,
  output logic             Done0,
  output logic             Done1,
  output logic [31:0]      Result,
  output logic [3:0]       Flags,
  output logic [31:0]      ALU_A,
  output logic [31:0]      ALU_B,
  output logic [4:0]       ALU_FunSel,
  output logic             ALU_WF,
  input  logic [31:0]      ALU_Out,
  input  logic [3:0]       ALU_Flags
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [31:0]      accum;
  logic [31:0]      b_reg;
  logic [31:0]      alu_a_hold;
  logic [4:0]       fun_reg;
  logic [CNT_W-1:0] iter;
  logic             owner;
  logic             grant0;
  logic             grant1;
  logic             take;
  logic [CNT_W-1:0] cnt_sel;

`ifdef ALU_ARB_RR_EN
  // rr_ptr names the requester that wins the next simultaneous request.
  logic rr_ptr;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rr_ptr <= 1'b0;
    end else if (take) begin
      rr_ptr <= ~grant1;
    end
  end

  assign grant1 = Req1 & (~Req0 | rr_ptr);
`else
  assign grant1 = Req1 & ~Req0;
`endif
  assign grant0 = Req0 & ~grant1;

  assign cnt_sel = grant1 ? Cnt1 : Cnt0;

  // The ALU sees the live accumulator only while iterating; otherwise the last driven value is held.
  assign ALU_A      = (state == ST_EXEC) ? accum : alu_a_hold;
  assign ALU_B      = b_reg;
  assign ALU_FunSel = fun_reg;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    Ack0      = 1'b0;
    Ack1      = 1'b0;
    take      = 1'b0;
    ALU_WF    = 1'b0;
    case (state)
      ST_IDLE: begin
        if ((Req0 | Req1) && !Reset) begin
          take      = 1'b1;
          Ack0      = grant0;
          Ack1      = grant1;
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        ALU_WF = 1'b1;
        if (iter == CNT_W'(1)) begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      accum      <= 32'd0;
      b_reg      <= 32'd0;
      alu_a_hold <= 32'd0;
      fun_reg    <= 5'd0;
      iter       <= CNT_W'(1);
      owner      <= 1'b0;
      Result     <= 32'd0;
      Flags      <= 4'd0;
      Done0      <= 1'b0;
      Done1      <= 1'b0;
    end else begin
      Done0 <= 1'b0;
      Done1 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (take) begin
            owner   <= grant1;
            fun_reg <= grant1 ? FunSel1 : FunSel0;
            b_reg   <= grant1 ? B1 : B0;
            accum   <= grant1 ? A1 : A0;
            iter    <= (cnt_sel == '0) ? CNT_W'(1) : cnt_sel;
          end
        end
        ST_EXEC: begin
          accum      <= ALU_Out;
          alu_a_hold <= accum;
          if (iter != CNT_W'(1)) begin
            iter <= iter - CNT_W'(1);
          end
        end
        ST_RESP: begin
          // ALU_Flags already holds the flags written by the final iteration.
          Result <= accum;
          Flags  <= ALU_Flags;
          Done0  <= ~owner;
          Done1  <= owner;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_request_arbiter.sv
// tb/tb_alu_request_arbiter.sv - scoreboard bench with a behavioural ALU fixture and command model
module tb_alu_request_arbiter;

  localparam logic [4:0] OP_ADD = 5'b10100;
  localparam logic [4:0] OP_SUB = 5'b10110;
  localparam logic [4:0] OP_AND = 5'b10111;
  localparam logic [4:0] OP_XOR = 5'b11001;
  localparam logic [4:0] OP_LSL = 5'b11011;
  localparam logic [4:0] OP_LSR = 5'b11100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [4:0]  fs0 = '0, fs1 = '0;
  logic [31:0] a0 = '0, a1 = '0, b0 = '0, b1 = '0;
  logic [4:0]  cnt0 = '0, cnt1 = '0;
  logic        ack0, ack1, done0, done1, alu_wf;
  logic [31:0] result, alu_a, alu_b, alu_out;
  logic [3:0]  flags;
  logic [3:0]  alu_flags = 4'h0;
  logic [4:0]  alu_fs;
  logic [35:0] alu_res;

  int compared = 0;
  int failed   = 0;

  typedef struct {
    int          id;
    logic [31:0] res;
    logic [3:0]  flg;
    int          done_cyc;
    int          n;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  alu_request_arbiter #(.CNT_W(5)) dut (
    .Clock(clk), .Reset(rst),
    .Req0(req0), .Req1(req1),
    .FunSel0(fs0), .FunSel1(fs1),
    .A0(a0), .A1(a1), .B0(b0), .B1(b1),
    .Cnt0(cnt0), .Cnt1(cnt1),
    .Ack0(ack0), .Ack1(ack1), .Done0(done0), .Done1(done1),
    .Result(result), .Flags(flags),
    .ALU_A(alu_a), .ALU_B(alu_b), .ALU_FunSel(alu_fs), .ALU_WF(alu_wf),
    .ALU_Out(alu_out), .ALU_Flags(alu_flags)
  );

  // Single-step ALU behaviour: returns {Z,C,N,O,result}.
  function automatic logic [35:0] alu_fn(input logic [4:0] fs, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] w;
    logic [31:0] r;
    logic        c;
    logic        o;
    c = 1'b0;
    o = 1'b0;
    w = '0;
    case (fs)
      OP_ADD: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[31:0];
        c = w[32];
        o = (a[31] == b[31]) && (r[31] != a[31]);
      end
      OP_SUB: begin
        w = {1'b0, a} - {1'b0, b};
        r = w[31:0];
        c = ~w[32];
        o = (a[31] != b[31]) && (r[31] != a[31]);
      end
      OP_AND: r = a & b;
      OP_XOR: r = a ^ b;
      OP_LSL: begin r = a << 1; c = a[31]; end
      OP_LSR: begin r = a >> 1; c = a[0]; end
      default: r = a;
    endcase
    return {(r == 32'd0), c, r[31], o, r};
  endfunction

  // Whole-command model: A fed through the op max(cnt,1) times, flags from the last step.
  function automatic logic [35:0] ref_cmd(input logic [4:0] fs, input logic [31:0] a, input logic [31:0] b, input logic [4:0] cnt);
    int          n;
    logic [31:0] acc;
    logic [3:0]  f;
    logic [35:0] s;
    n   = (cnt == 5'd0) ? 1 : int'(cnt);
    acc = a;
    f   = 4'h0;
    for (int i = 0; i < n; i++) begin
      s   = alu_fn(fs, acc, b);
      acc = s[31:0];
      f   = s[35:32];
    end
    return {f, acc};
  endfunction

  assign alu_res = alu_fn(alu_fs, alu_a, alu_b);
  assign alu_out = alu_res[31:0];

  always @(posedge clk) begin
    if (alu_wf) alu_flags <= alu_res[35:32];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: arbitration model on Ack, scoreboard pop on Done, reset output check.
  int cyc       = 0;
  int next_free = 0;
  int ptr       = 0;
  int wf_cnt    = 0;

  always @(negedge clk) begin
    int exp_id;
    int act_id;
    int n;
    exp_t e;
    logic [35:0] m;
    cyc++;
    if (rst) begin
      chk("reset_outputs",
          {27'd0, ack0, ack1, done0, done1, alu_wf, flags, alu_fs},
          64'd0);
      chk("reset_data", {result, alu_a ^ alu_b}, 64'd0);
      chk("reset_alu_a", {32'd0, alu_a}, 64'd0);
      sb.delete();
      ptr       = 0;
      next_free = cyc + 1;
      wf_cnt    = 0;
    end else begin
      if (alu_wf) wf_cnt++;
      if (done0 || done1) begin
        chk("done_onehot", done0 & done1, 0);
        if (sb.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("done_id", done1 ? 1 : 0, e.id);
          chk("done_result", result, e.res);
          chk("done_flags", flags, e.flg);
          chk("done_cycle", cyc, e.done_cyc);
          chk("wf_cycles", wf_cnt, e.n);
        end
      end else if (sb.size() != 0 && cyc > sb[0].done_cyc) begin
        chk("done_missing", 0, 1);
        void'(sb.pop_front());
      end

      exp_id = -1;
      if (cyc >= next_free) begin
`ifdef ALU_ARB_RR_EN
        if (req0 && req1) exp_id = ptr;
`else
        if (req0 && req1) exp_id = 0;
`endif
        else if (req0) exp_id = 0;
        else if (req1) exp_id = 1;
      end
      act_id = ack0 ? 0 : (ack1 ? 1 : -1);
      if (ack0 || ack1) chk("ack_onehot", ack0 & ack1, 0);
      if (exp_id != -1 || act_id != -1) chk("ack_winner", act_id, exp_id);
      if (act_id >= 0) begin
        if (act_id == 0) begin
          m = ref_cmd(fs0, a0, b0, cnt0);
          n = (cnt0 == 0) ? 1 : int'(cnt0);
        end else begin
          m = ref_cmd(fs1, a1, b1, cnt1);
          n = (cnt1 == 0) ? 1 : int'(cnt1);
        end
        e.id       = act_id;
        e.res      = m[31:0];
        e.flg      = m[35:32];
        e.done_cyc = cyc + n + 2;
        e.n        = n;
        sb.push_back(e);
        next_free  = cyc + n + 2;
        ptr        = 1 - act_id;
        wf_cnt     = 0;
      end
    end
  end

  task automatic load(input int k, input logic [4:0] fs, input logic [31:0] a, input logic [31:0] b, input logic [4:0] cnt);
    if (k == 0) begin fs0 = fs; a0 = a; b0 = b; cnt0 = cnt; end
    else        begin fs1 = fs; a1 = a; b1 = b; cnt1 = cnt; end
  endtask

  task automatic set_req(input int k, input logic v);
    if (k == 0) req0 = v; else req1 = v;
  endtask

  task automatic wait_ack(input int k, input int bound, output bit got);
    got = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if ((k == 0) ? ack0 : ack1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic drive_req(input int k, input logic [4:0] fs, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] cnt, input bit abandon);
    bit got;
    @(posedge clk); #1;
    load(k, fs, a, b, cnt);
    set_req(k, 1'b1);
    wait_ack(k, abandon ? 1 : 5000, got);
    @(posedge clk); #1;
    set_req(k, 1'b0);
    if (!abandon) chk("ack_timeout", got, 1);
  endtask

  task automatic wait_done(input int k, input logic [31:0] exp_res, input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((k == 0) ? done0 : done1) begin
        got = 1'b1;
        break;
      end
    end
    chk({name, "_done_seen"}, got, 1);
    if (got) chk(name, result, exp_res);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
    chk("drain", sb.size(), 0);
  endtask

  task automatic rand_driver(input int k);
    logic [4:0] ops [6];
    logic [4:0] cnt;
    ops = '{OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_LSL, OP_LSR};
    for (int t = 0; t < 30; t++) begin
      repeat ($urandom_range(0, 4)) @(posedge clk);
      cnt = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
      drive_req(k, ops[$urandom_range(0, 5)], $urandom, $urandom, cnt, $urandom_range(0, 7) == 0);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int prev;
    int id;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // First simultaneous request after reset goes to requester 0.
    #1;
    load(0, OP_ADD, 32'd10, 32'd1, 5'd2);
    load(1, OP_SUB, 32'd10, 32'd1, 5'd2);
    req0 = 1'b1;
    req1 = 1'b1;
    @(negedge clk);
    chk("first_simul_ack", {ack0, ack1}, 2'b10);
    @(posedge clk); #1 req0 = 1'b0;
    wait_ack(1, 50, got);
    chk("second_ack1_seen", got, 1);
    @(posedge clk); #1 req1 = 1'b0;
    drain();

    drive_req(0, OP_ADD, 32'd5, 32'd3, 5'd1, 1'b0);
    wait_done(0, 32'd8, "add_single");
    chk("add_single_z", flags[3], 1'b0);
    drive_req(1, OP_ADD, 32'd0, 32'd7, 5'd4, 1'b0);
    wait_done(1, 32'd28, "add_times4");
    drive_req(0, OP_SUB, 32'd4, 32'd4, 5'd1, 1'b0);
    wait_done(0, 32'd0, "sub_zero");
    chk("sub_zero_z", flags[3], 1'b1);
    drive_req(0, OP_LSR, 32'h80, 32'd0, 5'd3, 1'b0);
    wait_done(0, 32'h10, "lsr_by3");
    drive_req(1, OP_LSL, 32'd1, 32'd0, 5'd0, 1'b0);
    wait_done(1, 32'd2, "cnt_zero_as_one");

    // Both requesters held with single-step commands.
    @(posedge clk); #1;
    load(0, OP_ADD, 32'd1, 32'd1, 5'd1);
    load(1, OP_XOR, 32'hF0, 32'h0F, 5'd1);
    req0 = 1'b1;
    req1 = 1'b1;
    prev = -1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        id = ack0 ? 0 : 1;
`ifdef ALU_ARB_RR_EN
        if (prev >= 0) chk("rr_alternate", id, 1 - prev);
`else
        chk("fixed_ack0_only", id, 0);
`endif
        prev = id;
      end
    end
    @(posedge clk); #1;
    req0 = 1'b0;
    req1 = 1'b0;
    drain();

    // Reset in the third iteration drops the command; the held request is taken again.
    @(posedge clk); #1;
    load(0, OP_ADD, 32'd1, 32'd2, 5'd8);
    req0 = 1'b1;
    wait_ack(0, 50, got);
    chk("long_ack_seen", got, 1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    wait_ack(0, 10, got);
    chk("reack_after_reset", got, 1);
    @(posedge clk); #1 req0 = 1'b0;
    wait_done(0, 32'd17, "after_reset_result");

    fork
      rand_driver(0);
      rand_driver(1);
    join
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
